sd_cmd_ctrl: RTL and testbench

Native-mode SD bus CMD-line controller for the attosoc SD port. Generates sd_clk from the system clock and serialises 48-bit commands with CRC7. Captures and checks 48-bit responses, with timeout. Sits between the CPU peripheral register bank and the sd_clk/sd_cmd pads; the DAT lines are out of scope.

---
 rtl/sd_cmd_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
// SD native-mode CMD-line controller: sd_clk generation, 48-bit command
// serialisation with CRC7, response capture/check with start-bit timeout.
module sd_cmd_ctrl #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned RESP_TIMEOUT = 64,
   parameter int unsigned NCC_GAP      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic        resp_en,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        crc_err,
   output logic [5:0]  resp_index,
   output logic [31:0] resp_arg,
   output logic        sd_clk,
   output logic        sd_cmd_o,
   output logic        sd_cmd_oe,
   input  logic        sd_cmd_i
);

   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TO_W    = $clog2(RESP_TIMEOUT + 1);
   localparam int unsigned GAP_W   = $clog2(NCC_GAP + 1);
   localparam int unsigned FRAME_W = 48;
   localparam int unsigned BIT_W   = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_RECV,
      S_GAP
   } state_t;

   // CRC7, polynomial x^7 + x^3 + 1, zero seed, MSB first
   function automatic logic [6:0] f_crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
      end
      return c;
   endfunction

   state_t             r_state, w_state_nxt;
   logic [DIV_W-1:0]   r_div_cnt;
   logic               r_sd_clk;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_timeout, w_timeout_nxt;
   logic               r_crc_err, w_crc_err_nxt;
   logic [5:0]         r_resp_index, w_resp_index_nxt;
   logic [31:0]        r_resp_arg, w_resp_arg_nxt;
   logic               r_cmd_o, w_cmd_o_nxt;
   logic               r_cmd_oe, w_cmd_oe_nxt;
   logic [FRAME_W-1:0] r_frame, w_frame_nxt;
   logic               r_resp_en, w_resp_en_nxt;
   logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic [TO_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
   logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
   logic [46:0]        r_rx, w_rx_nxt;

   logic               w_div_tc;
   logic               w_fall_en;
   logic               w_rise_en;
   logic               w_accept;
   logic [6:0]         w_crc_tx;
   logic [47:0]        w_rx_shift;
   logic [6:0]         w_crc_rx;

   assign w_div_tc   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
   assign w_fall_en  = w_div_tc & r_sd_clk;
   assign w_rise_en  = w_div_tc & ~r_sd_clk;
   assign w_accept   = cmd_start & ~r_busy;
   assign w_crc_tx   = f_crc7({2'b01, cmd_index, cmd_arg});
   assign w_rx_shift = {r_rx, sd_cmd_i};
   assign w_crc_rx   = f_crc7(w_rx_shift[47:8]);

   // Free-running sd_clk divider, runs in IDLE too so the card gets init clocks
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_sd_clk  <= 1'b0;
      end else if (w_div_tc) begin
         r_div_cnt <= '0;
         r_sd_clk  <= ~r_sd_clk;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
         r_crc_err    <= 1'b0;
         r_resp_index <= '0;
         r_resp_arg   <= '0;
         r_cmd_o      <= 1'b1;
         r_cmd_oe     <= 1'b0;
         r_frame      <= '0;
         r_resp_en    <= 1'b0;
         r_bit_cnt    <= '0;
         r_wait_cnt   <= '0;
         r_gap_cnt    <= '0;
         r_rx         <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_timeout    <= w_timeout_nxt;
         r_crc_err    <= w_crc_err_nxt;
         r_resp_index <= w_resp_index_nxt;
         r_resp_arg   <= w_resp_arg_nxt;
         r_cmd_o      <= w_cmd_o_nxt;
         r_cmd_oe     <= w_cmd_oe_nxt;
         r_frame      <= w_frame_nxt;
         r_resp_en    <= w_resp_en_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_wait_cnt   <= w_wait_cnt_nxt;
         r_gap_cnt    <= w_gap_cnt_nxt;
         r_rx         <= w_rx_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_busy_nxt       = r_busy;
      w_done_nxt       = 1'b0;
      w_timeout_nxt    = r_timeout;
      w_crc_err_nxt    = r_crc_err;
      w_resp_index_nxt = r_resp_index;
      w_resp_arg_nxt   = r_resp_arg;
      w_cmd_o_nxt      = r_cmd_o;
      w_cmd_oe_nxt     = r_cmd_oe;
      w_frame_nxt      = r_frame;
      w_resp_en_nxt    = r_resp_en;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_wait_cnt_nxt   = r_wait_cnt;
      w_gap_cnt_nxt    = r_gap_cnt;
      w_rx_nxt         = r_rx;

      case (r_state)
         S_IDLE: begin
            w_cmd_oe_nxt = 1'b0;
            w_cmd_o_nxt  = 1'b1;
            if (w_accept) begin
               w_busy_nxt    = 1'b1;
               w_frame_nxt   = {2'b01, cmd_index, cmd_arg, w_crc_tx, 1'b1};
               w_resp_en_nxt = resp_en;
               w_timeout_nxt = 1'b0;
               w_crc_err_nxt = 1'b0;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = S_SEND;
            end
         end

         // Bit 47 stays on the line one full sd_clk before oe is released
         S_SEND: begin
            if (w_fall_en) begin
               if (r_bit_cnt == BIT_W'(FRAME_W)) begin
                  w_cmd_oe_nxt   = 1'b0;
                  w_cmd_o_nxt    = 1'b1;
                  w_wait_cnt_nxt = '0;
                  w_gap_cnt_nxt  = '0;
                  w_state_nxt    = r_resp_en ? S_WAIT : S_GAP;
               end else begin
                  w_cmd_o_nxt   = r_frame[FRAME_W-1];
                  w_cmd_oe_nxt  = 1'b1;
                  w_frame_nxt   = {r_frame[FRAME_W-2:0], 1'b0};
                  w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
               end
            end
         end

         // Start bit is checked before the timeout count, so it wins on the last edge
         S_WAIT: begin
            if (w_rise_en) begin
               if (!sd_cmd_i) begin
                  w_rx_nxt      = w_rx_shift[46:0];
                  w_bit_cnt_nxt = BIT_W'(1);
                  w_state_nxt   = S_RECV;
               end else if (r_wait_cnt == TO_W'(RESP_TIMEOUT - 1)) begin
                  w_timeout_nxt = 1'b1;
                  w_gap_cnt_nxt = '0;
                  w_state_nxt   = S_GAP;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + TO_W'(1);
               end
            end
         end

         S_RECV: begin
            if (w_rise_en) begin
               w_rx_nxt = w_rx_shift[46:0];
               if (r_bit_cnt == BIT_W'(FRAME_W - 1)) begin
                  w_resp_index_nxt = w_rx_shift[45:40];
                  w_resp_arg_nxt   = w_rx_shift[39:8];
                  w_crc_err_nxt    = w_rx_shift[46] | ~w_rx_shift[0] |
                                     (w_crc_rx != w_rx_shift[7:1]);
                  w_gap_cnt_nxt    = '0;
                  w_state_nxt      = S_GAP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
               end
            end
         end

         S_GAP: begin
            w_cmd_oe_nxt = 1'b0;
            if (w_fall_en) begin
               if (r_gap_cnt == GAP_W'(NCC_GAP - 1)) begin
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign timeout    = r_timeout;
   assign crc_err    = r_crc_err;
   assign resp_index = r_resp_index;
   assign resp_arg   = r_resp_arg;
   assign sd_clk     = r_sd_clk;
   assign sd_cmd_o   = r_cmd_o;
   assign sd_cmd_oe  = r_cmd_oe;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: bench-side card model, serial stream capture,
// hand-computed frames and CRC bytes.
module tb_sd_cmd_ctrl;

   logic        clk;
   logic        rst;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        resp_en;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        crc_err;
   logic [5:0]  resp_index;
   logic [31:0] resp_arg;
   logic        sd_clk;
   logic        sd_cmd_o;
   logic        sd_cmd_oe;
   logic        sd_cmd_i;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_edge_viol = 0;

   logic [47:0] cap_stream;
   int          cap_ndone;
   bit          busy_dropped;
   time         t_oe, t_done, t_r0, t_r1;

   logic        prev_o, prev_oe, prev_sck;

   sd_cmd_ctrl #(
      .CLK_DIV      (4),
      .RESP_TIMEOUT (64),
      .NCC_GAP      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_start  (cmd_start),
      .cmd_index  (cmd_index),
      .cmd_arg    (cmd_arg),
      .resp_en    (resp_en),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .crc_err    (crc_err),
      .resp_index (resp_index),
      .resp_arg   (resp_arg),
      .sd_clk     (sd_clk),
      .sd_cmd_o   (sd_cmd_o),
      .sd_cmd_oe  (sd_cmd_oe),
      .sd_cmd_i   (sd_cmd_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // CMD output or oe may only move in the clk cycle where sd_clk falls
   always @(posedge clk) begin
      #1;
      if (!rst && ((sd_cmd_o !== prev_o) || (sd_cmd_oe !== prev_oe)) &&
          !(prev_sck === 1'b1 && sd_clk === 1'b0))
         n_edge_viol++;
      prev_o   = sd_cmd_o;
      prev_oe  = sd_cmd_oe;
      prev_sck = sd_clk;
   end

   task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ren);
      @(negedge clk);
      cmd_start = 1'b1;
      cmd_index = idx;
      cmd_arg   = arg;
      resp_en   = ren;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic card_reply(input logic [47:0] rsp);
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (sd_cmd_oe) break;
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge sd_clk); #1;
         if (!sd_cmd_oe) break;
      end
      repeat (2) @(negedge sd_clk);
      for (int b = 0; b < 48; b++) begin
         #1 sd_cmd_i = rsp[47-b];
         @(negedge sd_clk);
      end
      #1 sd_cmd_i = 1'b1;
   endtask

   task automatic txn(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                      input bit reply, input logic [47:0] rsp, input bit poke);
      issue_cmd(idx, arg, ren);
      cap_stream   = '0;
      cap_ndone    = 0;
      busy_dropped = 1'b0;
      t_oe         = 0;
      t_done       = 0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               @(posedge clk); #1;
               if (sd_cmd_oe) break;
            end
            t_oe = $time;
            for (int b = 0; b < 48; b++) begin
               @(posedge sd_clk); #1;
               if (b == 0) t_r0 = $time;
               if (b == 1) t_r1 = $time;
               cap_stream = {cap_stream[46:0], sd_cmd_o};
            end
            for (int k = 0; k < 4000; k++) begin
               @(posedge clk); #1;
               if (done) begin
                  cap_ndone++;
                  t_done = $time;
               end
               if (!busy) begin
                  busy_dropped = 1'b1;
                  break;
               end
            end
         end
         begin
            if (reply) begin
               card_reply(rsp);
            end else if (poke) begin
               repeat (100) @(negedge clk);
               cmd_start = 1'b1;
               cmd_index = 6'h3F;
               cmd_arg   = 32'hFFFF_FFFF;
               resp_en   = 1'b1;
               @(negedge clk);
               cmd_start = 1'b0;
            end
         end
      join
      chk_val("busy_drop", 64'(busy_dropped), 64'd1);
   endtask

   initial begin
      int n_done_rst;
      rst       = 1'b1;
      cmd_start = 1'b0;
      cmd_index = '0;
      cmd_arg   = '0;
      resp_en   = 1'b0;
      sd_cmd_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_val("rst_busy",    64'(busy),       64'd0);
      chk_val("rst_done",    64'(done),       64'd0);
      chk_val("rst_timeout", 64'(timeout),    64'd0);
      chk_val("rst_crc_err", 64'(crc_err),    64'd0);
      chk_val("rst_rindex",  64'(resp_index), 64'd0);
      chk_val("rst_rarg",    64'(resp_arg),   64'd0);
      chk_val("rst_sd_clk",  64'(sd_clk),     64'd0);
      chk_val("rst_cmd_o",   64'(sd_cmd_o),   64'd1);
      chk_val("rst_cmd_oe",  64'(sd_cmd_oe),  64'd0);
      @(negedge clk);
      rst = 1'b0;

      // CMD0, no response: first bit to done is 48 bits + 8 gap = 56 sd_clk periods of 80
      txn(6'd0, 32'h0, 1'b0, 1'b0, 48'h0, 1'b0);
      chk_val("cmd0_stream",  64'(cap_stream),    64'h40_0000_0000_95);
      chk_val("cmd0_ndone",   64'(cap_ndone),     64'd1);
      chk_val("cmd0_latency", 64'(t_done - t_oe), 64'd4480);
      chk_val("cmd0_timeout", 64'(timeout),       64'd0);
      chk_val("cmd0_crc_err", 64'(crc_err),       64'd0);
      chk_val("cmd0_period",  64'(t_r1 - t_r0),   64'd80);

      // CMD8 with R7 echo; CRC7 of 0x08000001AA is 0x09, so the CRC byte is 0x13
      txn(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 48'h08_0000_01AA_13, 1'b0);
      chk_val("cmd8_stream",  64'(cap_stream), 64'h48_0000_01AA_87);
      chk_val("cmd8_rindex",  64'(resp_index), 64'h08);
      chk_val("cmd8_rarg",    64'(resp_arg),   64'h0000_01AA);
      chk_val("cmd8_crc_err", 64'(crc_err),    64'd0);
      chk_val("cmd8_timeout", 64'(timeout),    64'd0);
      chk_val("cmd8_ndone",   64'(cap_ndone),  64'd1);

      // Corrupted CRC byte
      txn(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 48'h08_0000_01AA_86, 1'b0);
      chk_val("bad_crc_err", 64'(crc_err),    64'd1);
      chk_val("bad_rarg",    64'(resp_arg),   64'h0000_01AA);
      chk_val("bad_rindex",  64'(resp_index), 64'h08);
      chk_val("bad_ndone",   64'(cap_ndone),  64'd1);

      // No reply: 64 rise edges then 8 gap falls -> done 119 periods after the first bit
      txn(6'd0, 32'h0, 1'b1, 1'b0, 48'h0, 1'b0);
      chk_val("to_stream",  64'(cap_stream),    64'h40_0000_0000_95);
      chk_val("to_timeout", 64'(timeout),       64'd1);
      chk_val("to_crc_err", 64'(crc_err),       64'd0);
      chk_val("to_rindex",  64'(resp_index),    64'h08);
      chk_val("to_rarg",    64'(resp_arg),      64'h0000_01AA);
      chk_val("to_ndone",   64'(cap_ndone),     64'd1);
      chk_val("to_latency", 64'(t_done - t_oe), 64'd9520);

      // cmd_start while busy must be ignored
      txn(6'd8, 32'h0000_01AA, 1'b0, 1'b0, 48'h0, 1'b1);
      chk_val("busy_stream",  64'(cap_stream),    64'h48_0000_01AA_87);
      chk_val("busy_ndone",   64'(cap_ndone),     64'd1);
      chk_val("busy_timeout", 64'(timeout),       64'd0);
      chk_val("busy_latency", 64'(t_done - t_oe), 64'd4480);
      chk_val("busy_period",  64'(t_r1 - t_r0),   64'd80);
      chk_val("edge_viol",    64'(n_edge_viol),   64'd0);

      // Reset while bit 20 is on the line
      issue_cmd(6'd0, 32'h0, 1'b0);
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (sd_cmd_oe) break;
      end
      for (int b = 0; b < 20; b++) @(posedge sd_clk);
      @(negedge sd_clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_val("mid_rst_oe",     64'(sd_cmd_oe), 64'd0);
      chk_val("mid_rst_busy",   64'(busy),      64'd0);
      chk_val("mid_rst_sd_clk", 64'(sd_clk),    64'd0);
      chk_val("mid_rst_cmd_o",  64'(sd_cmd_o),  64'd1);
      chk_val("mid_rst_rarg",   64'(resp_arg),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      n_done_rst = 0;
      repeat (600) begin
         @(posedge clk); #1;
         if (done) n_done_rst++;
      end
      chk_val("mid_rst_no_done", 64'(n_done_rst), 64'd0);

      txn(6'd0, 32'h0, 1'b0, 1'b0, 48'h0, 1'b0);
      chk_val("post_rst_stream",  64'(cap_stream), 64'h40_0000_0000_95);
      chk_val("post_rst_ndone",   64'(cap_ndone),  64'd1);
      chk_val("post_rst_timeout", 64'(timeout),    64'd0);
      chk_val("post_rst_crc_err", 64'(crc_err),    64'd0);
      chk_val("post_rst_rindex",  64'(resp_index), 64'd0);
      chk_val("edge_viol_final",  64'(n_edge_viol), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
